// File: rtl/uart_pkg.sv
// Shared UART package: transmit FSM state type and default parameters for the TX and RX paths.
// UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package uart_pkg;

  localparam int unsigned DefDataBits   = 8;
  localparam int unsigned DefFifoDepth  = 4;
  localparam int unsigned DefClksPerBit = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO: storage, pointers, count, empty/full flags and sticky overflow.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_req_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(Depth));
  assign overflow_o = overflow_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  // Full is the registered flag, so a write while full drops even if a pop lands this edge.
  assign push = wr_req_i && !full_o;
  assign pop  = pop_i && !empty_o;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_req_i && full_o);
    if (push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered serializer (start, LSB-first data, optional parity, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DefDataBits,
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth,
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Write_En,
  input  logic                 BIST_Mode,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 Tx_Done,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end, load, pop;
  logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_tx_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .wr_req_i   (Write_En && !BIST_Mode),
    .wdata_i    (Tx_Data),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .empty_o    (FIFO_Empty),
    .full_o     (FIFO_Full),
    .overflow_o (FIFO_Overflow)
  );

  assign bit_end = (cnt_q == CntLast);
  assign Tx      = tx_q;
  assign Tx_Busy = (state_q != IDLE);
  assign Tx_Done = (state_q == STOP) && bit_end;

  // tx_d always carries the line level of the state being entered, keeping Tx registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end
    case (state_q)
      IDLE: load = !FIFO_Empty;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          load    = !FIFO_Empty;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_rdata;
      state_d = START;
      cnt_d   = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected words, a line monitor decodes frames.
module tb_uart_tx;

  localparam int DB  = 8;
  localparam int CPB = 4;
  localparam int FD  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = DB + 3;
`else
  localparam int FrameBits = DB + 2;
`endif
  localparam int FrameClks = FrameBits * CPB;

  logic          Clk;
  logic          Rst;
  logic [DB-1:0] Tx_Data;
  logic          Write_En;
  logic          BIST_Mode;
  logic          Tx, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow;

  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  sb [$];

  uart_tx #(
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (FD),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Tx_Data       (Tx_Data),
    .Write_En      (Write_En),
    .BIST_Mode     (BIST_Mode),
    .Tx            (Tx),
    .Tx_Busy       (Tx_Busy),
    .Tx_Done       (Tx_Done),
    .FIFO_Empty    (FIFO_Empty),
    .FIFO_Full     (FIFO_Full),
    .FIFO_Overflow (FIFO_Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Tx_Busy) busy_cnt++;
    if (Tx_Done) done_cnt++;
  end

  // Line monitor: decode each frame by sampling mid-bit; Tx_Done must hit only the last cycle.
  initial begin
    logic [FrameBits-1:0] bits;
    logic [7:0]           exp;
    bit                   aborted, done_ok;
    forever begin
      @(negedge Clk);
      if (!Rst && Tx == 1'b0) begin
        bits    = '0;
        aborted = 1'b0;
        done_ok = (Tx_Done == 1'b0);
        for (int k = 1; k < FrameClks; k++) begin
          @(negedge Clk);
          if (Rst) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == CPB / 2) bits[k/CPB] = Tx;
          if (Tx_Done != (k == FrameClks - 1)) done_ok = 1'b0;
        end
        if (!aborted) begin
          if (sb.size() == 0) begin
            check("frame_unexpected", int'(bits[DB:1]), -1);
          end else begin
            exp = sb.pop_front();
            check("frame_data", int'(bits[DB:1]), int'(exp));
            check("frame_start_stop", int'({bits[0], bits[FrameBits-1]}), 1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", int'(bits[DB+1]), int'(^exp));
`endif
            check("frame_done_timing", int'(done_ok), 1);
          end
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input logic bist);
    @(negedge Clk);
    Tx_Data   = d;
    Write_En  = 1'b1;
    BIST_Mode = bist;
  endtask

  task automatic wr_end();
    @(negedge Clk);
    Write_En  = 1'b0;
    BIST_Mode = 1'b0;
  endtask

  task automatic clear_counts();
    @(negedge Clk);
    #1;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_idle(input int budget, output int empty_viol);
    int n;
    n = 0;
    empty_viol = 0;
    do begin
      @(negedge Clk);
      n++;
      if (Tx_Busy && !FIFO_Empty) empty_viol++;
    end while ((Tx_Busy || !FIFO_Empty) && n < budget);
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int viol;
    Rst = 1'b1;
    Write_En = 1'b0;
    BIST_Mode = 1'b0;
    Tx_Data = '0;
    repeat (3) @(negedge Clk);
    check("rst_tx", int'(Tx), 1);
    check("rst_empty", int'(FIFO_Empty), 1);
    check("rst_full", int'(FIFO_Full), 0);
    check("rst_overflow", int'(FIFO_Overflow), 0);
    check("rst_busy", int'(Tx_Busy), 0);
    check("rst_done", int'(Tx_Done), 0);
    Rst = 1'b0;

    // Single word 0xA5.
    clear_counts();
    sb.push_back(8'hA5);
    wr(8'hA5, 1'b0);
    wr_end();
    wait_idle(200, viol);
    check("a5_empty_during_frame", viol, 0);
    check("a5_busy_cycles", busy_cnt, FrameClks);
    check("a5_done_pulses", done_cnt, 1);

    // Six back-to-back writes: one popped, four fill, the sixth overflows.
    clear_counts();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) sb.push_back(8'(i));
      wr(8'(i), 1'b0);
    end
    wr_end();
    check("burst_full", int'(FIFO_Full), 1);
    check("burst_overflow", int'(FIFO_Overflow), 1);
    wait_idle(600, viol);
    check("burst_busy_cycles", busy_cnt, 5 * FrameClks);
    check("burst_done_pulses", done_cnt, 5);
    check("burst_overflow_sticky", int'(FIFO_Overflow), 1);

    // 0x07: odd popcount, parity bit 1 when enabled.
    clear_counts();
    sb.push_back(8'h07);
    wr(8'h07, 1'b0);
    wr_end();
    wait_idle(200, viol);
    check("p07_busy_cycles", busy_cnt, FrameClks);
    check("p07_done_pulses", done_cnt, 1);

    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("overflow_cleared", int'(FIFO_Overflow), 0);

    // BIST_Mode blocks host writes.
    wr(8'h3C, 1'b1);
    wr_end();
    viol = 0;
    repeat (20) begin
      @(negedge Clk);
      if (!FIFO_Empty || !Tx || Tx_Busy) viol++;
    end
    check("bist_ignored", viol, 0);
    check("bist_no_overflow", int'(FIFO_Overflow), 0);

    // Reset during data bit 3 with two words queued.
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr_end();
    check("midrst_queued", int'(FIFO_Empty), 0);
    repeat (16) @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("midrst_tx_high", int'(Tx), 1);
    check("midrst_empty", int'(FIFO_Empty), 1);
    check("midrst_busy", int'(Tx_Busy), 0);
    @(negedge Clk);
    Rst = 1'b0;
    viol = 0;
    repeat (60) begin
      @(negedge Clk);
      if (!Tx || Tx_Busy || !FIFO_Empty) viol++;
    end
    check("midrst_no_restart", viol, 0);

    // Normal operation resumes after reset.
    sb.push_back(8'h5A);
    wr(8'h5A, 1'b0);
    wr_end();
    wait_idle(200, viol);
    repeat (4) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART: buffers parallel words from the host in a small circular FIFO and serializes them onto the line as start, data (LSB first), optional parity and stop bits. It sits between the host write port and the `Tx` pin. It mirrors the receive FIFO's flag set (`FIFO_Empty`, `FIFO_Full`, `FIFO_Overflow`) and `BIST_Mode` gating, so the host drives both directions the same way.

## Interface
- `DATA_BITS`, 8, payload bits per frame (5..9)
- `FIFO_DEPTH`, 4, words of buffering; power of 2, ≥2
- `CLKS_PER_BIT`, 16, `Clk` cycles per serial bit (≥2)
- `Clk`  input  1  single clock; all state on rising edge
- `Rst`  input  1  asynchronous, active-high reset
- `Tx_Data`  input  DATA_BITS  word to enqueue
- `Write_En`  input  1  enqueue `Tx_Data` this cycle
- `BIST_Mode`  input  1  when 1, host writes are ignored; frame in progress completes
- `Tx`  output  1  serial line, idle high
- `Tx_Busy`  output  1  frame in progress (state ≠ IDLE)
- `Tx_Done`  output  1  one-cycle pulse at end of each stop bit
- `FIFO_Empty`  output  1  count == 0
- `FIFO_Full`  output  1  count == FIFO_DEPTH
- `FIFO_Overflow`  output  1  sticky: a write was dropped because FIFO full

## Operation
- Reset values: `Tx`=1, `Tx_Busy`=0, `Tx_Done`=0, `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0; pointers, count and state cleared. Reset mid-frame aborts immediately; the line goes high asynchronously.
- FIFO: write pointer, read pointer, count, each $clog2(FIFO_DEPTH) (+1 for count) wide; pointers wrap modulo FIFO_DEPTH. Flags are decoded from the registered count.
- Write accepted when `Write_En && !BIST_Mode && !FIFO_Full` (registered flag). A write while full is dropped even if a pop happens the same edge; it sets `FIFO_Overflow`, which stays set until `Rst`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- IDLE: if count > 0, pop into shift register, go to START.
- START: `Tx`=0 for CLKS_PER_BIT cycles.
- DATA: shift out DATA_BITS bits LSB first, each CLKS_PER_BIT cycles.
- PARITY: only present with the macro (see Configuration).
- STOP: `Tx`=1 for CLKS_PER_BIT cycles. On the last cycle `Tx_Done` pulses. If count > 0, pop and go to START directly, with no idle bit; otherwise go to IDLE.
- Bit-time counter: 0..CLKS_PER_BIT-1, reloaded on every bit boundary. Bit index counter: 0..DATA_BITS-1.

## Timing
- Write at edge E raises count after E. IDLE pop occurs at edge E+1. `Tx` falls after E+1.
- Frame length: (2 + DATA_BITS [+1 parity]) × CLKS_PER_BIT cycles, with `Tx` registered.
- `Tx_Done` is high for exactly one cycle, coincident with the final cycle of the stop bit.
- `Tx_Busy` rises with START entry and falls with IDLE entry. It stays high across back-to-back frames.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state follows DATA and transmits the even-parity bit (XOR of data bits) for CLKS_PER_BIT cycles. The frame grows by one bit.
- Undefined: DATA goes straight to STOP, no parity logic is synthesized, and the PARITY state is absent from the enum.

## Structure
- Shared package `uart_pkg`: `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP) and the default parameter constants used by both the TX and RX paths.
- One sub-module, `uart_tx_fifo`: storage array, pointers, count, flags and overflow. The top holds the FSM, counters and shift register.

## Test plan
(Use DATA_BITS=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.)
- Assert `Rst` → `Tx`=1, `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0, `Tx_Busy`=0, `Tx_Done`=0.
- Write 0xA5 once → `Tx` low for 4 clocks, then data bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks. `Tx_Done` pulses once 40 clocks after start. `FIFO_Empty`=1 throughout the frame.
- Write 0x01..0x06 on 6 consecutive edges while idle → 0x01 popped, 0x02..0x05 fill the FIFO (`FIFO_Full`=1), 0x06 dropped, `FIFO_Overflow`=1. Line carries 0x01..0x05 back-to-back with no idle gap. `Tx_Busy` is high for 200 clocks.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit 1 after bit 7. Frame is 44 clocks and `Tx_Done` fires at clock 44.
- Write 0x3C with `BIST_Mode`=1 → write ignored, `FIFO_Empty` stays 1, `Tx` stays 1, no overflow.
- Assert `Rst` during DATA bit 3 of a frame with 2 words queued → `Tx`=1 immediately, `FIFO_Empty`=1. After release, no frame starts until the next write.
